// File: rtl/uart_pkg.sv
// Shared UART definitions: controller state encoding, frame geometry and
// the cycles-per-bit calculation used by both the transmitter and receiver.
package uart_pkg;

  // Two-state link controller: waiting for a byte, or shifting a frame out.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } uart_state_e;

  // Start bit + 8 data bits + stop bit.
  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);

  // Clock cycles spent on each serial bit (integer division, truncating).
  function automatic int unsigned cycles_per_bit(input int unsigned clock_freq,
                                                 input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Per-bit cycle counter: counts 0..N-1 while enabled and raises Tick on the
// last cycle of each bit so the controller can move to the next bit.
module uart_baud_counter #(
  parameter int unsigned N = 10
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clear,
  output logic Tick
);

  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  // A bit period shorter than two cycles leaves no room for the idle gap.
  if (N < 2) begin : g_bad_n
    $error("uart_baud_counter: N must be at least 2");
  end

  logic [CNT_W-1:0] count;

  // Cycle counter: held at zero while cleared, wraps after N-1.
  always_ff @(posedge Clock or negedge Reset) begin
    // NOTE: non-blocking (<=) for every flop so all registers update from
    // pre-edge values; blocking here would create order-dependent races.
    if (!Reset) begin
      count <= '0;
    end else if (Clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign Tick = !Clear && (count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a valid/ready byte interface. A byte is latched
// into a 10-bit frame on handshake and shifted out LSB first; the line is
// idle high and every output is registered so SOut only moves at bit edges.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 33_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] DataIn,
  input  logic       DataInValid,
  output logic       DataInReady,
  output logic       SOut
);

  localparam int unsigned N = cycles_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  uart_state_e           state;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [BIT_CNT_W-1:0]  next_bit;
  logic [FRAME_BITS-1:0] frame;
  logic                  handshake;
  logic                  count_clear;
  logic                  bit_tick;

  assign handshake   = DataInValid && DataInReady;
  assign count_clear = (state == IDLE);
  assign next_bit    = bit_cnt + BIT_CNT_W'(1);

  uart_baud_counter #(
    .N(N)
  ) u_baud_counter (
    .Clock(Clock),
    .Reset(Reset),
    .Clear(count_clear),
    .Tick (bit_tick)
  );

  // Frame controller: accepts a byte in IDLE, steps through the frame bits
  // on each baud tick while BUSY, and returns to IDLE after the stop bit.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      // NOTE: the frame register is reset (all ones = line idle) because a
      // mid-frame reset must leave no stale data bits behind; plain data
      // storage that is always written before use would not need a reset.
      frame       <= '1;
      DataInReady <= 1'b1;
      SOut        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            frame       <= {1'b1, DataIn, 1'b0};
            bit_cnt     <= '0;
            state       <= BUSY;
            DataInReady <= 1'b0;
            SOut        <= 1'b0;
          end
        end
        BUSY: begin
          if (bit_tick) begin
            if (bit_cnt == LAST_BIT) begin
              state       <= IDLE;
              bit_cnt     <= '0;
              frame       <= '1;
              DataInReady <= 1'b1;
              SOut        <= 1'b1;
            end else begin
              bit_cnt <= next_bit;
              SOut    <= frame[next_bit];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at N = 10 cycles per bit. The
// expected line waveform is built from the frame {stop, data, start}: cycle
// H+c (c = 1..10N) carries frame bit (c-1)/N, and cycle H+10N+1 is idle.
module tb_uart_transmitter;

  localparam int unsigned CLOCK_FREQ = 1000;
  localparam int unsigned BAUD_RATE  = 100;
  localparam int          N          = CLOCK_FREQ / BAUD_RATE;
  localparam int          FRAME_LEN  = 10 * N;

  logic       Clock;
  logic       Reset;
  logic [7:0] DataIn;
  logic       DataInValid;
  logic       DataInReady;
  logic       SOut;

  int checks   = 0;
  int failures = 0;

  uart_transmitter #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .DataIn     (DataIn),
    .DataInValid(DataInValid),
    .DataInReady(DataInReady),
    .SOut       (SOut)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Offer a byte at the next falling edge and wait (bounded) until the
  // transmitter shows ready; the following rising edge is then H.
  task automatic start_byte(input logic [7:0] d);
    int waited;
    waited = 0;
    @(negedge Clock);
    DataIn      = d;
    DataInValid = 1'b1;
    while (DataInReady !== 1'b1 && waited < 200) begin
      @(negedge Clock);
      waited++;
    end
    if (waited >= 200) check("ready_timeout", 32'(DataInReady), 32'd1);
  endtask

  // Watch one frame cycle by cycle starting right before edge H.
  //   keep_valid : hold DataInValid and present next_d for a back-to-back byte
  //   change_at  : cycle at which DataIn is overwritten with change_val
  //   abort_at   : cycle at which Reset is asserted mid-frame (frame ends there)
  task automatic check_frame(input logic [7:0] d, input bit keep_valid,
                             input logic [7:0] next_d, input int change_at,
                             input logic [7:0] change_val, input int abort_at);
    logic [9:0] frame_bits;
    logic [7:0] rx;
    logic       exp_sout;
    logic       exp_rdy;
    frame_bits = {1'b1, d, 1'b0};
    rx = '0;
    for (int c = 1; c <= FRAME_LEN + 1; c++) begin
      @(negedge Clock);
      if (c == 1 && !keep_valid) DataInValid = 1'b0;
      exp_sout = (c <= FRAME_LEN) ? frame_bits[(c - 1) / N] : 1'b1;
      exp_rdy  = (c > FRAME_LEN);
      check($sformatf("sout[%02h] c=%0d", d, c), 32'(SOut), 32'(exp_sout));
      check($sformatf("ready[%02h] c=%0d", d, c), 32'(DataInReady), 32'(exp_rdy));
      // Receiver-style mid-bit sampling of the eight data bits.
      if (c > N && c <= 9 * N && ((c - 1) % N) == N / 2) rx[(c - 1) / N - 1] = SOut;
      if (c == change_at) DataIn = change_val;
      if (c == abort_at) begin
        Reset = 1'b0;
        #1;
        check("abort_sout", 32'(SOut), 32'd1);
        check("abort_ready", 32'(DataInReady), 32'd1);
        return;
      end
      if (keep_valid && c == FRAME_LEN + 1) DataIn = next_d;
    end
    check($sformatf("rx_byte[%02h]", d), 32'(rx), 32'(d));
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] nd;
    bit         chained;
    bit         keep;
    int         gap;

    // Reset held with a producer already offering data: nothing may start.
    Reset       = 1'b0;
    DataIn      = 8'hA5;
    DataInValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      check($sformatf("rst_sout%0d", i), 32'(SOut), 32'd1);
      check($sformatf("rst_ready%0d", i), 32'(DataInReady), 32'd1);
    end
    DataInValid = 1'b0;
    Reset       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check($sformatf("post_rst_sout%0d", i), 32'(SOut), 32'd1);
      check($sformatf("post_rst_ready%0d", i), 32'(DataInReady), 32'd1);
    end

    // Single byte.
    start_byte(8'hA5);
    check_frame(8'hA5, 1'b0, 8'h00, -1, 8'h00, -1);

    // Back-to-back: exactly one idle-high cycle between frames.
    start_byte(8'h00);
    check_frame(8'h00, 1'b1, 8'hFF, -1, 8'h00, -1);
    check_frame(8'hFF, 1'b0, 8'h00, -1, 8'h00, -1);

    // DataIn changes after the handshake must not reach the line.
    start_byte(8'h3C);
    check_frame(8'h3C, 1'b0, 8'h00, 5, 8'hC3, -1);

    // Mid-frame reset, then a byte offered across reset release.
    start_byte(8'hF0);
    check_frame(8'hF0, 1'b0, 8'h00, -1, 8'h00, 37);
    DataIn      = 8'h55;
    DataInValid = 1'b1;
    @(negedge Clock);
    check("hold_rst_sout", 32'(SOut), 32'd1);
    check("hold_rst_ready", 32'(DataInReady), 32'd1);
    Reset = 1'b1;
    check_frame(8'h55, 1'b0, 8'h00, -1, 8'h00, -1);

    // Random bytes with random idle gaps and random chaining.
    chained = 1'b0;
    d       = 8'(($urandom));
    for (int k = 0; k < 8; k++) begin
      if (!chained) begin
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) @(negedge Clock);
        d = 8'($urandom);
        start_byte(d);
      end
      keep = 1'($urandom_range(0, 1));
      if (k == 7) keep = 1'b0;
      nd = 8'($urandom);
      check_frame(d, keep, nd, -1, 8'h00, -1);
      chained = keep;
      d       = nd;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
